// File: rtl/mem_access_initiator.sv
// mem_access_initiator
//   Memory-stage initiator. Turns an M-stage load/store into a req/gnt/rvalid
//   transaction on the word-organised data memory. Stores present word address,
//   lane enables and lane-replicated data. Loads extract and extend the
//   addressed byte/half/word. Holds the pipeline while the transaction is in
//   flight and reports address-error and response-timeout exceptions.
//
//   state  | meaning
//   IDLE   | waiting for a valid op
//   REQ    | mem_req asserted, waiting for mem_gnt
//   WAIT_R | load granted, waiting for mem_rvalid (bounded by TIMEOUT)
//   DONE   | one-cycle completion pulse, result/exception valid
//
// Ports
//   clk, reset                    clock, synchronous active-high reset
//   op_valid, op, addr, wdata     M-stage operation (held stable while stall)
//   flush                         abandon the op in REQ (before gnt) or WAIT_R
//   stall                         hold pipeline
//   done, load_data, exc, exc_code  completion pulse and its result
//   mem_req, mem_we, mem_addr, mem_byteen, mem_wdata  registered request
//   mem_gnt, mem_rvalid, mem_rdata  memory handshake and read data
module mem_access_initiator #(
  parameter int TIMEOUT  = 64,
  parameter int EXC_ADEL = 4,
  parameter int EXC_ADES = 5,
  parameter int EXC_BUS  = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [3:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic        exc,
  output logic [4:0]  exc_code,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_byteen,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [3:0] OP_LW  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LB  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LH  = 4'd5;
  localparam logic [3:0] OP_SW  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SB  = 4'd8;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_R, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          drop_q, drop_d;
  logic [3:0]    op_q, op_d;
  logic [1:0]    alo_q, alo_d;
  logic          mem_req_d, mem_we_d;
  logic [31:0]   mem_addr_d, mem_wdata_d;
  logic [3:0]    mem_byteen_d;
  logic [31:0]   load_data_d;
  logic          exc_d;
  logic [4:0]    exc_code_d;

  logic          in_load, in_store, in_misal, op_active;
  logic [3:0]    in_byteen;
  logic [31:0]   in_wdata;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   ext_data;

  // Incoming op decode: alignment, lane enables, replicated store data.
  always_comb begin
    in_load   = 1'b0;
    in_store  = 1'b0;
    in_misal  = 1'b0;
    in_byteen = 4'b0000;
    in_wdata  = 32'h0;
    case (op)
      OP_LW: begin
        in_load  = 1'b1;
        in_misal = (addr[1:0] != 2'b00);
      end
      OP_LBU, OP_LB: in_load = 1'b1;
      OP_LHU, OP_LH: begin
        in_load  = 1'b1;
        in_misal = addr[0];
      end
      OP_SW: begin
        in_store  = 1'b1;
        in_misal  = (addr[1:0] != 2'b00);
        in_byteen = 4'b1111;
        in_wdata  = wdata;
      end
      OP_SH: begin
        in_store  = 1'b1;
        in_misal  = addr[0];
        in_byteen = addr[1] ? 4'b1100 : 4'b0011;
        in_wdata  = {2{wdata[15:0]}};
      end
      OP_SB: begin
        in_store  = 1'b1;
        in_byteen = 4'b0001 << addr[1:0];
        in_wdata  = {4{wdata[7:0]}};
      end
      default: ;
    endcase
  end

  assign op_active = op_valid & (in_load | in_store);
  assign done      = (state_q == S_DONE);
  assign stall     = op_active & ~done;

  // Load extraction from the latched op and byte offset.
  always_comb begin
    byte_sel = mem_rdata[{alo_q, 3'b000} +: 8];
    half_sel = alo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ext_data = 32'h0;
    case (op_q)
      OP_LW:  ext_data = mem_rdata;
      OP_LBU: ext_data = {24'h0, byte_sel};
      OP_LB:  ext_data = {{24{byte_sel[7]}}, byte_sel};
      OP_LHU: ext_data = {16'h0, half_sel};
      OP_LH:  ext_data = {{16{half_sel[15]}}, half_sel};
      default: ext_data = 32'h0;
    endcase
  end

  assign cnt_inc = cnt_q + CW'(1);

  // Result registers default to zero so load_data/exc/exc_code are only
  // nonzero during the DONE cycle.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    drop_d       = drop_q;
    op_d         = op_q;
    alo_d        = alo_q;
    mem_req_d    = mem_req;
    mem_we_d     = mem_we;
    mem_addr_d   = mem_addr;
    mem_byteen_d = mem_byteen;
    mem_wdata_d  = mem_wdata;
    load_data_d  = 32'h0;
    exc_d        = 1'b0;
    exc_code_d   = 5'd0;
    case (state_q)
      S_IDLE: begin
        drop_d = 1'b0;
        cnt_d  = '0;
        if (op_active) begin
          op_d  = op;
          alo_d = addr[1:0];
          if (in_misal) begin
            state_d    = S_DONE;
            exc_d      = 1'b1;
            exc_code_d = in_load ? 5'(EXC_ADEL) : 5'(EXC_ADES);
          end else begin
            state_d      = S_REQ;
            mem_req_d    = 1'b1;
            mem_we_d     = in_store;
            mem_addr_d   = {addr[31:2], 2'b00};
            mem_byteen_d = in_byteen;
            mem_wdata_d  = in_wdata;
          end
        end
      end
      S_REQ: begin
        cnt_d = '0;
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          if (mem_we) begin
            // A store granted together with flush has already been written;
            // it simply completes silently.
            state_d = flush ? S_IDLE : S_DONE;
          end else begin
            state_d = S_WAIT_R;
            drop_d  = flush;
          end
        end else if (flush) begin
          mem_req_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      S_WAIT_R: begin
        if (flush) drop_d = 1'b1;
        if (mem_rvalid) begin
          if (drop_q | flush) begin
            state_d = S_IDLE;
          end else begin
            state_d     = S_DONE;
            load_data_d = ext_data;
          end
        end else if (cnt_inc == CW'(TIMEOUT)) begin
          if (drop_q | flush) begin
            state_d = S_IDLE;
          end else begin
            state_d    = S_DONE;
            exc_d      = 1'b1;
            exc_code_d = 5'(EXC_BUS);
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      drop_q     <= 1'b0;
      op_q       <= 4'd0;
      alo_q      <= 2'd0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'h0;
      mem_byteen <= 4'b0000;
      mem_wdata  <= 32'h0;
      load_data  <= 32'h0;
      exc        <= 1'b0;
      exc_code   <= 5'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      drop_q     <= drop_d;
      op_q       <= op_d;
      alo_q      <= alo_d;
      mem_req    <= mem_req_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_byteen <= mem_byteen_d;
      mem_wdata  <= mem_wdata_d;
      load_data  <= load_data_d;
      exc        <= exc_d;
      exc_code   <= exc_code_d;
    end
  end

endmodule

// File: tb/tb_mem_access_initiator.sv
module tb_mem_access_initiator;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [3:0]  op;
  logic [31:0] addr, wdata;
  logic        flush;
  logic        stall, done, exc, mem_req, mem_we;
  logic [31:0] load_data, mem_addr, mem_wdata;
  logic [4:0]  exc_code;
  logic [3:0]  mem_byteen;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int n_vec = 0;
  int n_err = 0;

  localparam int LIMIT = 75;

  always #5 clk = ~clk;

  mem_access_initiator dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .addr(addr),
    .wdata(wdata), .flush(flush), .stall(stall), .done(done),
    .load_data(load_data), .exc(exc), .exc_code(exc_code),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_byteen(mem_byteen), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    op_valid = 1'b0; op = 4'd0; addr = 32'h0; wdata = 32'h0; flush = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
  endtask

  // Reference: load result from the full word and the byte address.
  function automatic logic [31:0] ref_load(input int o, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> ((a % 4) * 8)) & 32'hFF;
    h = (w >> (((a % 4) >= 2) ? 16 : 0)) & 32'hFFFF;
    case (o)
      1: return w;
      2: return b;
      3: return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      4: return h;
      5: return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      default: return 32'h0;
    endcase
  endfunction

  // One op, acting as the pipeline and the memory. gd = gnt delay in REQ
  // cycles, rd = rvalid cycles after gnt (>64 = never), fl = flush cycle (-1 none).
  task automatic run_op(input int o, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd_word, input int gd, input int rd, input int fl);
    bit is_op, is_ld, is_st, bad;
    int g, exp_done, exp_req, exp_code, exp_exc;
    logic [31:0] exp_data, exp_addr, exp_wd;
    logic [3:0]  exp_be;
    int done_cyc, done_cnt, req_cnt, gcyc;
    logic [31:0] got_data;
    logic got_exc, got_stall1;
    logic [4:0] got_code;
    int fld_bad, idle_bad;

    is_op = (o >= 1 && o <= 8);
    is_ld = (o >= 1 && o <= 5);
    is_st = (o >= 6 && o <= 8);
    bad   = ((o == 1 || o == 6) && (a % 4 != 0)) ||
            ((o == 4 || o == 5 || o == 7) && (a % 2 != 0));
    g = 1 + gd;
    exp_data = 32'h0; exp_exc = 0; exp_code = 0;
    exp_addr = a & 32'hFFFF_FFFC;
    exp_be   = (o == 6) ? 4'd15 : (o == 7) ? 4'(3 << (a % 4)) : (o == 8) ? 4'(1 << (a % 4)) : 4'd0;
    exp_wd   = (o == 6) ? wd : (o == 7) ? (wd & 32'hFFFF) * 32'h0001_0001 :
               (o == 8) ? (wd & 32'hFF) * 32'h0101_0101 : 32'h0;
    if (!is_op) begin
      exp_done = -1; exp_req = 0;
    end else if (bad) begin
      exp_done = 1; exp_req = 0; exp_exc = 1; exp_code = is_ld ? 4 : 5;
    end else if (fl >= 1 && fl < g) begin
      exp_done = -1; exp_req = fl;
    end else begin
      exp_req = g;
      if (is_st) exp_done = g + 1;
      else if (rd <= 64) begin
        exp_done = g + rd + 1; exp_data = ref_load(o, a, rd_word);
      end else begin
        exp_done = g + 65; exp_exc = 1; exp_code = 6;
      end
      if (fl >= g + 1 && fl < exp_done) exp_done = -1;
    end

    done_cyc = -1; done_cnt = 0; req_cnt = 0; gcyc = -1;
    got_data = 0; got_exc = 0; got_code = 0; got_stall1 = 0;
    fld_bad = 0; idle_bad = 0;

    @(posedge clk); #1;
    op_valid = 1'b1; op = 4'(o); addr = a; wdata = wd;
    #1 chk("stall_accept", {31'd0, stall}, {31'd0, is_op});
    for (int cyc = 1; cyc <= LIMIT; cyc++) begin
      @(posedge clk); #1;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; flush = 1'b0;
      if (cyc == 1) got_stall1 = stall;
      if (mem_req) begin
        req_cnt++;
        if (mem_addr !== exp_addr || mem_we !== is_st || mem_byteen !== exp_be ||
            mem_wdata !== exp_wd) fld_bad++;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc; got_data = load_data; got_exc = exc; got_code = exc_code;
        end
        op_valid = 1'b0;
      end else if (exc_code !== 5'd0 || exc !== 1'b0 || load_data !== 32'h0) idle_bad++;
      if (mem_req && req_cnt == gd + 1) begin
        mem_gnt = 1'b1; gcyc = cyc;
      end
      if (gcyc >= 0 && cyc == gcyc + rd && !is_st) begin
        mem_rvalid = 1'b1; mem_rdata = rd_word;
      end else if ((mem_req && !mem_gnt) || (exp_done >= 0 && cyc > exp_done)) begin
        mem_rvalid = ($urandom_range(0, 2) == 0); mem_rdata = $urandom;
      end
      if (cyc == fl) begin
        flush = 1'b1; op_valid = 1'b0;
      end
    end
    idle_inputs();

    chk("done_cycle", done_cyc, exp_done);
    chk("done_count", done_cnt, (exp_done >= 0) ? 1 : 0);
    chk("req_cycles", req_cnt, exp_req);
    chk("req_fields", fld_bad, 0);
    chk("idle_results", idle_bad, 0);
    chk("stall_cyc1", {31'd0, got_stall1}, (is_op && exp_done != 1) ? 1 : 0);
    if (exp_done >= 0) begin
      chk("load_data", got_data, exp_data);
      chk("exc", {31'd0, got_exc}, exp_exc);
      chk("exc_code", {27'd0, got_code}, exp_code);
    end
  endtask

  initial begin
    int o, gd, rd, fl, sz;
    logic [31:0] a;
    int dcnt;

    idle_inputs();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_mem_req", {31'd0, mem_req}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_byteen", {28'd0, mem_byteen}, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_load_data", load_data, 0);
    chk("rst_exc", {26'd0, exc, exc_code}, 0);
    chk("rst_stall", {31'd0, stall}, 0);

    // Directed cases
    run_op(8, 32'h0000_1003, 32'h0000_00AB, 32'h0, 0, 1, -1);
    run_op(3, 32'h0000_2002, 32'h0, 32'h1280_3456, 0, 1, -1);
    run_op(2, 32'h0000_2002, 32'h0, 32'h1280_3456, 0, 1, -1);
    run_op(5, 32'h0000_0002, 32'h0, 32'h8001_7FFF, 3, 1, -1);
    run_op(1, 32'h0000_0006, 32'h0, 32'h0, 0, 1, -1);
    run_op(7, 32'h0000_0001, 32'h1234_5678, 32'h0, 0, 1, -1);
    run_op(1, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 100, -1);
    run_op(1, 32'h0000_0010, 32'h0, 32'hCAFE_F00D, 0, 5, 3);
    run_op(6, 32'h0000_0020, 32'hA5A5_5A5A, 32'h0, 3, 1, 2);
    run_op(6, 32'h0000_0024, 32'h0102_0304, 32'h0, 0, 1, 2);
    run_op(4, 32'h0000_0032, 32'h0, 32'h9ABC_DEF0, 1, 64, -1);

    // Reset while a load waits for its response; the late rvalid is stray.
    @(posedge clk); #1;
    op_valid = 1'b1; op = 4'd1; addr = 32'h40;
    @(posedge clk); #1;
    chk("rstmid_req", {31'd0, mem_req}, 1);
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0; reset = 1'b1; op_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rstmid_req_drop", {31'd0, mem_req}, 0);
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
    dcnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      if (done || mem_req) dcnt++;
    end
    chk("rstmid_no_done", dcnt, 0);
    idle_inputs();

    // Randomized ops
    for (int n = 0; n < 60; n++) begin
      o  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 8);
      sz = (o == 1 || o == 6) ? 4 : (o == 4 || o == 5 || o == 7) ? 2 : 1;
      a  = $urandom;
      if ($urandom_range(0, 2) != 0) a = a & ~(32'(sz) - 32'd1);
      gd = $urandom_range(0, 4);
      rd = ($urandom_range(0, 9) == 0) ? 100 : $urandom_range(1, 6);
      fl = -1;
      if ($urandom_range(0, 4) == 0) begin
        fl = $urandom_range(1, 8);
        if (fl == gd + 1) fl = gd + 2;
      end
      run_op(o, a, $urandom, $urandom, gd, rd, fl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
